inhibit_stream: RTL
===================

# inhibit_stream

Parametrised, streaming successor of the two-input inhibit gate s = ~x & y. Processes WIDTH-bit vectors per beat under a valid/ready handshake, with a registered output stage. Selectable modes apply the inhibit between the two operands, or between consecutive samples of y, which gives rising, falling or any-edge detection. A saturating counter accumulates the number of set result bits; it is used as a self-checking event monitor in the exercise benches.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits (≥1)
- CNT_W, 16, event counter width (≥ $clog2(WIDTH+1))

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  input beat present
- in_ready  output  1  block can accept a beat
- in_x  input  WIDTH  operand x (used in mode 0 only)
- in_y  input  WIDTH  operand y / stream sample
- in_mode  input  2  0 inhibit, 1 rise, 2 fall, 3 any edge; sampled with the beat
- out_valid  output  1  result beat present
- out_ready  input  1  downstream accepts result
- out_s  output  WIDTH  result vector
- count_clr  input  1  synchronous clear of event_count and history
- event_count  output  CNT_W  saturating total of set bits in accepted results

## Operation
- Accept: a beat transfers when in_valid & in_ready. Output transfer happens when out_valid & out_ready.
- in_ready = ~out_valid | out_ready. This gives a single output register with no bubble under continuous flow.
- Result per accepted beat, bitwise:
  - mode 0: s = ~x & y
  - mode 1: s = ~prev & y
  - mode 2: s = prev & ~y
  - mode 3: s = prev ^ y
- prev is the y of the previous accepted beat, updated on every accept in every mode. prev is 0 after reset and after count_clr.
- event_count adds popcount(s) on each output transfer. It saturates at 2^CNT_W−1 and never wraps.
- count_clr (level, synchronous): clears event_count and prev.
  - It overrides a same-cycle increment, so the count becomes 0.
  - A beat accepted in that cycle computes its result with prev = 0. Its y then becomes the new prev.
- The output register holds out_s stable while out_valid & ~out_ready.

## Timing
- Reset values: in_ready 1, out_valid 0, out_s 0, event_count 0, prev 0. Asynchronous assertion clears them immediately. Deassertion is synchronised by the system.
- Latency: 1 cycle from accept to out_valid. Throughput is 1 beat/cycle while out_ready is held high.
- Backpressure: while out_valid & ~out_ready, in_ready is 0 and no beat is accepted. prev is unchanged.
- Simultaneous out transfer and in accept: the output register reloads with the new result. out_valid stays 1.
- Saturation boundary: when count + popcount exceeds the maximum, the count is clamped to 2^CNT_W−1.
- Reset mid-stream discards any held result. The first beat after reset sees prev = 0.

## Structure
- Shared package `inhibit_pkg` holds:
  - the mode enum (MODE_INHIBIT=0, MODE_RISE=1, MODE_FALL=2, MODE_ANY=3)
  - a function computing s from (mode, x, y, prev)
- Sub-module `popcount #(WIDTH)` is purely combinational and yields $clog2(WIDTH+1) bits. It feeds the saturating adder.
- The remaining logic is the handshake/output register, the prev register and the counter.

## Test plan
- Mode 0 truth table, WIDTH=8: x=8'h0F, y=8'h3C gives out_s=8'h30 one cycle later. Repeat over all four combinations of 1-bit lanes, x/y ∈ {00, 01, 10, 11} patterns. Lanes follow 0,1,0,0 exactly.
- Rise/fall stream: y sequence 8'h00, 8'hF0, 8'hFF, 8'h0F.
  - Mode 1 gives out_s 00, F0, 0F, 00.
  - Mode 2 gives 00, 00, 00, F0.
  - event_count after the mode 1 pass is 8.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1. in_ready stays 0, out_s stays stable, and no beat is lost or duplicated. Output order matches input order.
- Saturation: CNT_W=4, feed y=8'hFF in mode 0 with x=0 twice. event_count goes 8 then 15, and stays 15 on further beats.
- count_clr with a same-cycle beat (mode 3, prev=8'hAA, y=8'h55): out_s=8'h55 and event_count=0 on the next cycle. The following beat y=8'h55 gives out_s=0.
- Async reset asserted while out_valid=1: out_valid drops immediately and event_count is 0. The first post-reset mode 1 beat y=8'h01 gives out_s=8'h01.

Source files
------------

// File: rtl/inhibit_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : inhibit_pkg
// Description : Mode encoding and per-lane result function for inhibit_stream.
// Revision    : 1.0 - initial release
// ============================================================================
package inhibit_pkg;

    typedef enum logic [1:0] {
        MODE_INHIBIT = 2'd0,
        MODE_RISE    = 2'd1,
        MODE_FALL    = 2'd2,
        MODE_ANY     = 2'd3
    } mode_e;

    // One result lane; the edge modes compare y against its previous sample.
    function automatic logic inhibit_bit(mode_e mode, logic x, logic y, logic prev);
        logic s;
        case (mode)
            MODE_INHIBIT: s = ~x & y;
            MODE_RISE:    s = ~prev & y;
            MODE_FALL:    s = prev & ~y;
            default:      s = prev ^ y;
        endcase
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/inhibit_stream_if.sv
`default_nettype none
// ============================================================================
// Module      : inhibit_stream_if
// Description : Input and output valid/ready streams of inhibit_stream.
// Revision    : 1.0 - initial release
// ============================================================================
interface inhibit_stream_if
    import inhibit_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_x;
    logic [WIDTH-1:0] in_y;
    mode_e            in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_s;

    modport master (
        output in_valid, in_x, in_y, in_mode, out_ready,
        input  in_ready, out_valid, out_s
    );

    modport slave (
        input  in_valid, in_x, in_y, in_mode, out_ready,
        output in_ready, out_valid, out_s
    );
endinterface
`default_nettype wire

// File: rtl/inhibit_stream_popcount.sv
`default_nettype none
// ============================================================================
// Module      : popcount
// Description : Combinational count of set bits in a WIDTH-bit vector.
// Revision    : 1.0 - initial release
// ============================================================================
module popcount #(
    parameter int WIDTH = 8
) (
    input  wire logic [WIDTH-1:0]               data,
    output      logic [$clog2(WIDTH+1)-1:0]     ones
);
    localparam int c_OUT_W = $clog2(WIDTH+1);

    always_comb begin
        ones = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ones = ones + c_OUT_W'(data[i]);
        end
    end
endmodule
`default_nettype wire

// File: rtl/inhibit_stream.sv
`default_nettype none
// ============================================================================
// Module      : inhibit_stream
// Description : Streaming inhibit / edge detector with registered output and
//               saturating set-bit event counter.
// Revision    : 1.0 - initial release
// ============================================================================
module inhibit_stream
    import inhibit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    inhibit_stream_if.slave       bus,
    input  wire logic             count_clr,
    output      logic [CNT_W-1:0] event_count
);
    localparam int               c_POP_W   = $clog2(WIDTH+1);
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_s;
    logic [WIDTH-1:0] r_prev;
    logic [CNT_W-1:0] r_count;

    logic             w_accept;
    logic             w_out_xfer;
    logic [WIDTH-1:0] w_prev_eff;
    logic [WIDTH-1:0] w_s;
    logic [c_POP_W-1:0] w_pop;
    logic [CNT_W:0]   w_sum;
    logic [CNT_W-1:0] w_count_next;

    assign bus.in_ready  = ~r_out_valid | bus.out_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_s     = r_out_s;
    assign event_count   = r_count;

    assign w_accept   = bus.in_valid & bus.in_ready;
    assign w_out_xfer = r_out_valid & bus.out_ready;

    // A beat accepted together with count_clr sees a cleared history.
    assign w_prev_eff = count_clr ? '0 : r_prev;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        assign w_s[i] = inhibit_bit(bus.in_mode, bus.in_x[i], bus.in_y[i], w_prev_eff[i]);
    end

    popcount #(.WIDTH(WIDTH)) u_popcount (
        .data (r_out_s),
        .ones (w_pop)
    );

    // Both addends fit in CNT_W bits, so the carry flags an overflow.
    assign w_sum        = {1'b0, r_count} + (CNT_W+1)'(w_pop);
    assign w_count_next = w_sum[CNT_W] ? c_CNT_MAX : w_sum[CNT_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_s     <= '0;
            r_prev      <= '0;
            r_count     <= '0;
        end else begin
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_s     <= w_s;
            end else if (w_out_xfer) begin
                r_out_valid <= 1'b0;
            end

            if (w_accept) begin
                r_prev <= bus.in_y;
            end else if (count_clr) begin
                r_prev <= '0;
            end

            if (count_clr) begin
                r_count <= '0;
            end else if (w_out_xfer) begin
                r_count <= w_count_next;
            end
        end
    end
endmodule
`default_nettype wire
